// File: rtl/ex_pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pipe_slot
//  Brief    : Multi-lane valid/ready pipeline slot between execute
//             sub-stages. It handles per-lane cancel masking and a
//             whole-slot flush.
//             When the build macro PIPE_SLOT_SKID_EN is defined, the slot
//             holds two entries (head plus skid), so backpressure costs no
//             throughput and up_ready_o is fully registered.
//             Otherwise the slot is a single head register, and up_ready_o
//             passes dn_ready_i through combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_pipe_slot #(
    parameter int              DW        = 64,
    parameter int              LANES     = 2,
    parameter logic [DW-1:0]   KILL_MASK = DW'(64'h1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [LANES*DW-1:0]   up_data_i,
    input  logic [LANES-1:0]      up_cancel_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [LANES*DW-1:0]   dn_data_o,
    output logic [LANES-1:0]      dn_cancel_o,
    output logic [1:0]            occ_o
);

    // The encoding equals the occupancy, so occ_o is taken straight from
    // the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 state_q,       state_d;
    logic                   dn_valid_q,    dn_valid_d;
    logic [LANES*DW-1:0]    head_data_q,   head_data_d;
    logic [LANES-1:0]       head_cancel_q, head_cancel_d;
`ifdef PIPE_SLOT_SKID_EN
    logic [LANES*DW-1:0]    skid_data_q,   skid_data_d;
    logic [LANES-1:0]       skid_cancel_q, skid_cancel_d;
    logic                   up_ready_q,    up_ready_d;
`endif

    logic                   w_up_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [LANES*DW-1:0]    w_in_data;

    // A cancelled lane stays in the slot as a bubble. Its write-enable style
    // bits (KILL_MASK) are cleared here, so downstream stages never act on it.
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            assign w_in_data[k*DW +: DW] = up_data_i[k*DW +: DW] &
                                           ~(up_cancel_i[k] ? KILL_MASK : {DW{1'b0}});
        end
    endgenerate

`ifdef PIPE_SLOT_SKID_EN
    // With a skid entry available, ready is a flop that depends only on the
    // occupancy.
    assign w_up_ready = up_ready_q;
`else
    // A single register can accept only when it is empty or is being
    // drained in this cycle.
    assign w_up_ready = ~dn_valid_q | dn_ready_i;
`endif

    // Qualify the handshakes. A flush suppresses both transfers.
    always_comb begin
        w_push = up_valid_i & w_up_ready & ~flush_i;
        w_pop  = dn_valid_q & dn_ready_i & ~flush_i;
    end

    // Compute the next occupancy and the next head/skid contents.
    always_comb begin
        state_d       = state_q;
        head_data_d   = head_data_q;
        head_cancel_d = head_cancel_q;
`ifdef PIPE_SLOT_SKID_EN
        skid_data_d   = skid_data_q;
        skid_cancel_d = skid_cancel_q;
`endif
        if (flush_i) begin
            // Data is left in place (don't-care). Cancel reads all-ones when
            // the slot is empty.
            state_d       = ST_EMPTY;
            head_cancel_d = '1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        state_d       = ST_ONE;
                        head_data_d   = w_in_data;
                        head_cancel_d = up_cancel_i;
                    end
                end
                ST_ONE: begin
`ifdef PIPE_SLOT_SKID_EN
                    if (w_push && w_pop) begin
                        head_data_d   = w_in_data;
                        head_cancel_d = up_cancel_i;
                    end else if (w_push) begin
                        state_d       = ST_TWO;
                        skid_data_d   = w_in_data;
                        skid_cancel_d = up_cancel_i;
                    end else if (w_pop) begin
                        state_d       = ST_EMPTY;
                        head_cancel_d = '1;
                    end
`else
                    // In this configuration a push while ONE always
                    // coincides with a pop.
                    if (w_push) begin
                        head_data_d   = w_in_data;
                        head_cancel_d = up_cancel_i;
                    end else if (w_pop) begin
                        state_d       = ST_EMPTY;
                        head_cancel_d = '1;
                    end
`endif
                end
`ifdef PIPE_SLOT_SKID_EN
                ST_TWO: begin
                    // ready is low in TWO, so only a pop can occur.
                    if (w_pop) begin
                        state_d       = ST_ONE;
                        head_data_d   = skid_data_q;
                        head_cancel_d = skid_cancel_q;
                    end
                end
`endif
                default: begin
                    state_d       = ST_EMPTY;
                    head_cancel_d = '1;
                end
            endcase
        end
        dn_valid_d = (state_d != ST_EMPTY);
`ifdef PIPE_SLOT_SKID_EN
        up_ready_d = (state_d != ST_TWO);
`endif
    end

    // State and registered outputs. Reset empties the slot immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            dn_valid_q    <= 1'b0;
            head_data_q   <= '0;
            head_cancel_q <= '1;
`ifdef PIPE_SLOT_SKID_EN
            skid_data_q   <= '0;
            skid_cancel_q <= '1;
            up_ready_q    <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            dn_valid_q    <= dn_valid_d;
            head_data_q   <= head_data_d;
            head_cancel_q <= head_cancel_d;
`ifdef PIPE_SLOT_SKID_EN
            skid_data_q   <= skid_data_d;
            skid_cancel_q <= skid_cancel_d;
            up_ready_q    <= up_ready_d;
`endif
        end
    end

    assign up_ready_o  = w_up_ready;
    assign dn_valid_o  = dn_valid_q;
    assign dn_data_o   = head_data_q;
    assign dn_cancel_o = head_cancel_q;
    assign occ_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_pipe_slot
//  Brief    : Self-checking bench for ex_pipe_slot (DW=8, LANES=2,
//             KILL_MASK=8'h01). The bench uses a queue reference model, a
//             per-cycle compare process, directed literal checks and a
//             randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_pipe_slot;

    localparam int             DW    = 8;
    localparam int             LANES = 2;
    localparam logic [DW-1:0]  KILL  = 8'h01;
`ifdef PIPE_SLOT_SKID_EN
    localparam int             CAP   = 2;
`else
    localparam int             CAP   = 1;
`endif

    logic                  clk         = 1'b0;
    logic                  rst         = 1'b1;
    logic                  flush_i     = 1'b0;
    logic                  up_valid_i  = 1'b0;
    logic                  dn_ready_i  = 1'b0;
    logic [LANES*DW-1:0]   up_data_i   = '0;
    logic [LANES-1:0]      up_cancel_i = '0;
    logic                  up_ready_o;
    logic                  dn_valid_o;
    logic [LANES*DW-1:0]   dn_data_o;
    logic [LANES-1:0]      dn_cancel_o;
    logic [1:0]            occ_o;

    ex_pipe_slot #(.DW(DW), .LANES(LANES), .KILL_MASK(KILL)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_data_i   (up_data_i),
        .up_cancel_i (up_cancel_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_data_o   (dn_data_o),
        .dn_cancel_o (dn_cancel_o),
        .occ_o       (occ_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a FIFO of {cancel, masked data} with capacity CAP.
    logic [LANES+LANES*DW-1:0] q[$];
    bit m_push, m_pop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || dn_ready_i;
    endfunction

    function automatic logic [LANES+LANES*DW-1:0] m_entry(input logic [LANES*DW-1:0] d,
                                                          input logic [LANES-1:0] c);
        logic [LANES*DW-1:0] r;
        r = d;
        for (int l = 0; l < LANES; l++)
            if (c[l]) r[l*DW +: DW] = d[l*DW +: DW] & ~KILL;
        return {c, r};
    endfunction

    // Advance the model on every clock edge, and empty it when reset is asserted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            m_push = up_valid_i && m_ready() && !flush_i;
            m_pop  = (q.size() != 0) && dn_ready_i && !flush_i;
            if (flush_i) begin
                q.delete();
            end else begin
                if (m_pop)  void'(q.pop_front());
                if (m_push) q.push_back(m_entry(up_data_i, up_cancel_i));
            end
        end
    end

    // Compare the DUT against the model once per cycle, on the falling edge.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("dn_valid", dn_valid_o, q.size() != 0);
            chk("occ", occ_o, q.size());
            chk("up_ready", up_ready_o, m_ready());
            if (q.size() != 0) begin
                chk("dn_data", dn_data_o, q[0][LANES*DW-1:0]);
                chk("dn_cancel", dn_cancel_o, q[0][LANES+LANES*DW-1:LANES*DW]);
            end else begin
                chk("dn_cancel_empty", dn_cancel_o, 2'b11);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] c, input logic r);
        up_valid_i  = v;
        up_data_i   = d;
        up_cancel_i = c;
        dn_ready_i  = r;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", dn_valid_o, 1'b0);
        chk("rst_occ", occ_o, 2'd0);
        chk("rst_data", dn_data_o, 16'h0000);
        chk("rst_cancel", dn_cancel_o, 2'b11);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("ready_after_rst", up_ready_o, 1'b1);

        // Basic transfer.
        drive(1'b1, 16'hA53C, 2'b00, 1'b0);
        tick();
        chk("basic_data", dn_data_o, 16'hA53C);
        chk("basic_cancel", dn_cancel_o, 2'b00);
        drive(1'b0, 16'h0000, 2'b00, 1'b1);
        tick();

        // Cancel masking on lane 1.
        drive(1'b1, 16'hFFFF, 2'b10, 1'b1);
        tick();
        chk("cancel_data", dn_data_o, 16'hFEFF);
        chk("cancel_flags", dn_cancel_o, 2'b10);
        drive(1'b0, 16'h0000, 2'b00, 1'b1);
        tick();
        chk("cancel_drained", dn_valid_o, 1'b0);

        // Backpressure.
`ifdef PIPE_SLOT_SKID_EN
        drive(1'b1, 16'h0011, 2'b00, 1'b0);
        tick();
        drive(1'b1, 16'h0022, 2'b00, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 2'b00, 1'b0);
        chk("bp_occ", occ_o, 2'd2);
        chk("bp_ready", up_ready_o, 1'b0);
        chk("bp_head", dn_data_o, 16'h0011);
        tick();
        chk("bp_head_stable", dn_data_o, 16'h0011);
        dn_ready_i = 1'b1;
        tick();
        chk("bp_second", dn_data_o, 16'h0022);
        chk("bp_occ1", occ_o, 2'd1);
        tick();
        chk("bp_empty", dn_valid_o, 1'b0);
`else
        drive(1'b1, 16'h0011, 2'b00, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 2'b00, 1'b0);
        chk("bp_ready_low", up_ready_o, 1'b0);
        chk("bp_head", dn_data_o, 16'h0011);
        drive(1'b1, 16'h0022, 2'b00, 1'b1);
        #1;
        chk("bp_ready_comb", up_ready_o, 1'b1);
        tick();
        chk("bp_replace", dn_data_o, 16'h0022);
        drive(1'b0, 16'h0000, 2'b00, 1'b1);
        tick();
        chk("bp_empty", dn_valid_o, 1'b0);
`endif

        // Streaming at one entry per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(i), 2'b00, 1'b1);
            tick();
            chk("stream_data", dn_data_o, 16'(i));
            chk("stream_ready", up_ready_o, 1'b1);
        end
        drive(1'b0, 16'h0000, 2'b00, 1'b1);
        tick();
        chk("stream_done", dn_valid_o, 1'b0);

        // Flush colliding with push and pop.
        drive(1'b1, 16'h0011, 2'b00, 1'b0);
        tick();
        drive(1'b1, 16'h0022, 2'b00, 1'b0);
        tick();
        drive(1'b1, 16'h0077, 2'b00, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 16'h0000, 2'b00, 1'b1);
        chk("flush_occ", occ_o, 2'd0);
        chk("flush_valid", dn_valid_o, 1'b0);
        chk("flush_cancel", dn_cancel_o, 2'b11);
        repeat (3) begin
            tick();
            chk("flush_quiet", dn_valid_o, 1'b0);
        end

        // Asynchronous reset in the middle of a cycle, with the slot full.
        drive(1'b1, 16'h0033, 2'b00, 1'b0);
        tick();
        drive(1'b1, 16'h0044, 2'b00, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 2'b00, 1'b0);
        chk("pre_rst_occ", occ_o, 2'(CAP));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_occ", occ_o, 2'd0);
        chk("async_rst_valid", dn_valid_o, 1'b0);
        chk("async_rst_cancel", dn_cancel_o, 2'b11);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", up_ready_o, 1'b1);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 500; n++) begin
            up_valid_i  = ($urandom_range(0, 3) != 0);
            up_data_i   = 16'($urandom);
            up_cancel_i = 2'($urandom);
            dn_ready_i  = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush_i    = 1'b0;
        up_valid_i = 1'b0;
        dn_ready_i = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_pipe_slot.md
Name: ex_pipe_slot

Overview:
- Parametrised, multi-lane pipeline slot. It replaces hand-written hold/flush/cancel stage registers between execute sub-stages (ex -> ex2 -> mem).
- Carries LANES independent payload lanes (main plus aux issue slots) under one valid/ready handshake, with a 2-entry skid buffer so backpressure does not cost throughput.
- Applies per-lane cancel (forces lane write-enables off) and pipeline flush (drops all held entries).

Parameters:
- DW, 64, payload width per lane in bits.
- LANES, 2, number of payload lanes (1..4).
- KILL_MASK, 64'h1, per-lane bit mask of payload bits forced to 0 when the lane is cancelled (e.g. w_reg_en, wdata_en positions).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  pipeline flush; drops all stored entries.
- up_valid_i  in  1  upstream entry valid.
- up_ready_o  out  1  slot can accept an entry this cycle.
- up_data_i  in  LANES*DW  payloads; lane k occupies bits [k*DW +: DW].
- up_cancel_i  in  LANES  per-lane cancel accompanying the entry.
- dn_valid_o  out  1  head entry valid.
- dn_ready_i  in  1  downstream accepts head.
- dn_data_o  out  LANES*DW  head payloads (KILL_MASK bits already cleared for cancelled lanes).
- dn_cancel_o  out  LANES  head per-lane cancel flags.
- occ_o  out  2  entries held (0, 1 or 2).

Behaviour:
- Reset: asserted asynchronously; clears occupancy to EMPTY immediately, whatever the current state.
  - Outputs during/after reset: dn_valid_o=0, dn_data_o=0, dn_cancel_o all 1, occ_o=0, up_ready_o=1 after deassertion.
- Transfers:
  - push = up_valid_i & up_ready_o & !flush_i.
  - pop = dn_valid_o & dn_ready_i & !flush_i.
- Stored lane value on push: data_k & ~(up_cancel_i[k] ? KILL_MASK : 0); cancel_k = up_cancel_i[k]. Cancelled lanes still occupy the slot as bubbles; they are not dropped.
- States: EMPTY (occ 0), ONE (head register valid), TWO (head and skid registers valid).
  - EMPTY: push -> ONE.
  - ONE:
    - push & pop -> ONE; head takes the new entry.
    - push & !pop -> TWO; the new entry goes to skid.
    - pop & !push -> EMPTY.
  - TWO: pop -> ONE; head takes skid. Push is impossible in TWO.
- up_ready_o = (occ != TWO). It is registered and does not depend on dn_ready_i combinationally.
- Latency: an entry pushed at edge N is visible on dn_* after edge N when the slot was EMPTY or ONE with a same-cycle pop.
- Ordering: strictly FIFO.
- Full throughput: with dn_ready_i held 1, one entry per cycle.
- flush_i=1:
  - At the next edge the state becomes EMPTY.
  - The same-cycle up entry is discarded; no pop is counted.
  - dn_valid_o=0 from the next cycle.
  - Flush overrides push and pop when asserted in the same cycle.
- dn_data_o and dn_cancel_o are held stable while dn_valid_o=1 and dn_ready_i=0.
- When EMPTY, dn_cancel_o reads all 1s. dn_data_o holds its last value, which is don't-care.

Optional Feature:
- Macro: PIPE_SLOT_SKID_EN.
- Defined: 2-entry skid behaviour as specified above.
- Undefined: single head register only; states EMPTY/ONE.
  - up_ready_o = !dn_valid_o | dn_ready_i. This is combinational from dn_ready_i.
  - occ_o never exceeds 1.
  - Flush, cancel and masking rules are unchanged.

Test Plan:
- Reset and basic transfer (DW=8, LANES=2, KILL_MASK=8'h01):
  - Assert rst mid-cycle with occ=2 -> occ_o=0 and dn_valid_o=0 immediately; after release up_ready_o=1.
  - Push 16'hA5_3C -> next cycle dn_data_o=16'hA53C, dn_cancel_o=2'b00.
- Cancel masking: push 16'hFF_FF with up_cancel_i=2'b10 -> dn_data_o=16'hFE_FF, dn_cancel_o=2'b10.
- Backpressure (skid enabled):
  - dn_ready_i=0; push 8'h11 then 8'h22 -> occ_o=2, up_ready_o=0, dn_data_o stays the 8'h11 entry.
  - Release dn_ready_i -> 8'h11 then 8'h22 emerge on consecutive cycles.
- Streaming: dn_ready_i=1, up_valid_i=1 for 10 cycles with incrementing data 0..9 -> 10 entries out in order, up_ready_o never drops.
- Flush collision: occ=2, assert flush_i together with up_valid_i=1 and dn_ready_i=1 -> next cycle occ_o=0 and dn_valid_o=0; neither the incoming nor the head entry is ever seen downstream.
- PIPE_SLOT_SKID_EN undefined: dn_ready_i=0 with one entry held -> up_ready_o=0; raising dn_ready_i -> up_ready_o=1 in the same cycle and the new entry replaces the head at the edge.
